instr_feeder: RTL and testbench

Instruction-stream source for the 9-bit-instruction, 16-bit-datapath processor: it holds a small loadable program and drives the processor's 9-bit `din` input in lock-step with the processor's one-hot tick FSM. It replaces the manual switch input during automated runs. It presents each instruction word in the fetch tick. For MOV_I (opcode 3'b111) it presents the following word as the immediate in the decode tick. It advances its program counter accordingly and stops at the programmed length.

---
 rtl/instr_feeder_if.sv | 30 +++
 rtl/instr_feeder.sv | 242 ++++++++++++++++++++++++
 tb/tb_instr_feeder.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_feeder_if.sv
// Instruction feeder bus: processor tick input, program-load port, run
// request, and the instruction/status outputs back to the controller.
interface instr_feeder_if #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
);
  logic [3:0]  tick;       // processor one-hot tick state
  logic        prog_we;    // program word write strobe
  logic [AW-1:0] prog_addr; // program word address
  logic [8:0]  prog_data;  // program word
  logic [AW:0] prog_len;   // number of valid words, sampled at start
  logic        run;        // start request
  logic [8:0]  din;        // instruction/immediate to the processor
  logic [AW:0] pc;         // current word index
  logic        busy;       // high while armed or running
  logic        done;       // one-cycle completion pulse
  logic        err;        // sticky: MOV_I was last word without immediate

  // Controller / processor side drives the requests and the tick.
  modport master (
    output tick, prog_we, prog_addr, prog_data, prog_len, run,
    input  din, pc, busy, done, err
  );

  // The feeder consumes requests and produces the instruction stream.
  modport slave (
    input  tick, prog_we, prog_addr, prog_data, prog_len, run,
    output din, pc, busy, done, err
  );
endinterface

// File: rtl/instr_feeder.sv
// instr_feeder: small loadable program memory that drives the processor's
// 9-bit din input in lock-step with its one-hot tick FSM. The instruction is
// presented in the fetch tick; for MOV_I the following word is presented as
// the immediate in the decode tick of the same round.
module instr_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic          clk,
  input logic          rst,
  instr_feeder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [2:0]  OP_MOVI     = 3'b111;
  localparam logic [3:0]  TICK_FETCH  = 4'b0001;
  localparam logic [3:0]  TICK_DECODE = 4'b0010;
  localparam logic [3:0]  TICK_LAST   = 4'b1000;
  localparam logic [AW:0] PC_ZERO     = (AW+1)'(0);
  localparam logic [AW:0] PC_ONE      = (AW+1)'(1);
  localparam logic [AW:0] PC_TWO      = (AW+1)'(2);

  // Architectural state
  state_e        state_q, state_d;
  logic [AW:0]   pc_q,    pc_d;
  logic [AW:0]   len_q,   len_d;
  logic [2:0]    op_q,    op_d;
  logic          err_q,   err_d;
  logic          done_q,  done_d;
  logic          busy_q,  busy_d;

  // Program storage; deliberately has no reset so programs survive rst.
  logic [8:0]    mem_q [DEPTH];

  // Datapath helpers
  logic [AW:0]   pc_inc1_s;
  logic [AW:0]   pc_inc2_s;
  logic [AW-1:0] fetch_addr_s;
  logic [AW-1:0] imm_addr_s;
  logic [8:0]    fetch_word_s;
  logic [8:0]    imm_word_s;
  logic          pc_lt_len_s;
  logic          imm_avail_s;
  logic          start_empty_s;
  logic [8:0]    din_s;

  // pc is one bit wider than an address so it can reach DEPTH; only the low
  // AW bits index memory, and memory is only read while pc < len.
  assign pc_inc1_s     = pc_q + PC_ONE;
  assign pc_inc2_s     = pc_q + PC_TWO;
  assign fetch_addr_s  = pc_q[AW-1:0];
  assign imm_addr_s    = pc_inc1_s[AW-1:0];
  assign fetch_word_s  = mem_q[fetch_addr_s];
  assign imm_word_s    = mem_q[imm_addr_s];
  assign pc_lt_len_s   = (pc_q < len_q);
  assign imm_avail_s   = (pc_inc1_s < len_q);
  assign start_empty_s = (bus.prog_len == PC_ZERO);

  // Program memory write port, open only while idle.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && bus.prog_we) begin
      mem_q[bus.prog_addr] <= bus.prog_data;
    end
  end

  // din mux: combinational so it is stable for the whole tick cycle.
  always_comb begin
    din_s = 9'd0;
    case (state_q)
      ST_RUN: begin
        case (bus.tick)
          TICK_FETCH: begin
            if (pc_lt_len_s) begin
              din_s = fetch_word_s;
            end else begin
              din_s = 9'd0;
            end
          end
          TICK_DECODE: begin
            if (op_q == OP_MOVI && imm_avail_s) begin
              din_s = imm_word_s;
            end else begin
              din_s = 9'd0;
            end
          end
          default: din_s = 9'd0;
        endcase
      end
      default: din_s = 9'd0;
    endcase
  end

  // Next-state logic for the IDLE/ARM/RUN sequencer and its counters.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    op_d    = op_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.run) begin
          len_d = bus.prog_len;
          pc_d  = PC_ZERO;
          err_d = 1'b0;
          op_d  = 3'd0;
          if (start_empty_s) begin
            // Nothing to feed: complete immediately without arming.
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ARM;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        // Leave ARM on the last tick so RUN starts exactly on a fetch tick.
        if (bus.tick == TICK_LAST) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_RUN: begin
        case (bus.tick)
          TICK_FETCH: begin
            if (pc_lt_len_s) begin
              op_d = fetch_word_s[8:6];
              if (fetch_word_s[8:6] != OP_MOVI) begin
                pc_d = pc_inc1_s;
              end else begin
                // MOV_I: hold pc, the immediate is consumed in decode.
                pc_d = pc_q;
              end
            end else begin
              op_d = op_q;
            end
          end
          TICK_DECODE: begin
            if (op_q == OP_MOVI) begin
              if (imm_avail_s) begin
                pc_d = pc_inc2_s;
              end else begin
                // MOV_I was the final word: flag it and finish the round.
                err_d = 1'b1;
                pc_d  = len_q;
              end
            end else begin
              pc_d = pc_q;
            end
          end
          TICK_LAST: begin
            if (!pc_lt_len_s) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
          default: state_d = ST_RUN;
        endcase
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and status registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= PC_ZERO;
      len_q   <= PC_ZERO;
      op_q    <= 3'd0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      op_q    <= op_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.din  = din_s;
  assign bus.pc   = pc_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

  instr_feeder_chk #(.AW(AW)) u_chk (
    .clk    (clk),
    .rst    (rst),
    .busy_i (busy_q),
    .done_i (done_q),
    .din_i  (din_s),
    .pc_i   (pc_q),
    .len_i  (len_q)
  );

endmodule

// instr_feeder_chk: structural invariants of the feeder outputs.
module instr_feeder_chk #(
  parameter int AW = 4
) (
  input logic        clk,
  input logic        rst,
  input logic        busy_i,
  input logic        done_i,
  input logic [8:0]  din_i,
  input logic [AW:0] pc_i,
  input logic [AW:0] len_i
);

  // An idle feeder never drives the instruction bus.
  a_idle_quiet: assert property (@(posedge clk) disable iff (rst)
    (!busy_i |-> din_i == 9'd0));

  // Completion is only signalled from IDLE.
  a_done_idle: assert property (@(posedge clk) disable iff (rst)
    (done_i |-> !busy_i));

  // While active, pc never runs past the programmed length.
  a_pc_bound: assert property (@(posedge clk) disable iff (rst)
    (busy_i |-> pc_i <= len_i));

endmodule

// File: tb/tb_instr_feeder.sv
// Self-checking bench for instr_feeder: a processor-like tick generator, a
// reference model that queues the expected din words, and a negedge monitor
// that pops and compares every non-zero din against the queue.
module tb_instr_feeder;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef struct {
    logic [8:0]  din;
    logic [3:0]  tick;
    logic [AW:0] pc;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   done_cnt;
  exp_t sb_q[$];
  logic [8:0]  model_mem [DEPTH];
  logic [AW:0] exp_pc;
  logic        exp_err;

  instr_feeder_if #(.DEPTH(DEPTH)) bus ();

  instr_feeder #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Processor tick FSM model: rotates one-hot every cycle, 1 time unit after the edge.
  initial begin
    bus.tick = 4'b0001;
    forever begin
      @(posedge clk);
      #1;
      bus.tick = {bus.tick[2:0], bus.tick[3]};
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Monitor: every non-zero din must match the next scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.din != 9'd0) begin
        if (sb_q.size() == 0) begin
          check_eq("din_extra", {23'd0, bus.din}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("sb_din",  {23'd0, bus.din}, {23'd0, e.din});
          check_eq("sb_tick", {28'd0, bus.tick}, {28'd0, e.tick});
          check_eq("sb_pc",   {27'd0, bus.pc}, {27'd0, e.pc});
        end
      end
      if (bus.done) done_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int addr, input logic [8:0] data);
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr[AW-1:0];
    bus.prog_data = data;
    step();
    bus.prog_we   = 1'b0;
    model_mem[addr] = data;
  endtask

  // Reference model: expected din words, final pc and err for a run of len words.
  task automatic push_expect(input int len);
    exp_t e;
    int p;
    logic [8:0] w;
    p = 0;
    exp_err = 1'b0;
    while (p < len) begin
      w = model_mem[p];
      e.din = w; e.tick = 4'b0001; e.pc = p[AW:0];
      sb_q.push_back(e);
      if (w[8:6] == 3'b111) begin
        if (p + 1 < len) begin
          e.din = model_mem[p+1]; e.tick = 4'b0010; e.pc = p[AW:0];
          sb_q.push_back(e);
          p = p + 2;
        end else begin
          exp_err = 1'b1;
          p = len;
        end
      end else begin
        p = p + 1;
      end
    end
    exp_pc = p[AW:0];
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (bus.done) begin
        found = 1'b1;
        break;
      end
    end
    check_eq({tag, "_done_seen"}, {31'd0, found}, 32'd1);
  endtask

  // Full run: optional write alongside run, optional write attempts while busy.
  task automatic run_prog(input string tag, input int len, input bit we_with_run,
                          input bit we_busy, input int we_addr, input logic [8:0] we_data);
    int d0;
    if (we_with_run) model_mem[we_addr] = we_data;
    push_expect(len);
    d0 = done_cnt;
    bus.prog_len = len[AW:0];
    bus.run      = 1'b1;
    if (we_with_run) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = we_addr[AW-1:0];
      bus.prog_data = we_data;
    end
    step();
    bus.run     = 1'b0;
    bus.prog_we = 1'b0;
    if (len == 0) begin
      check_eq({tag, "_done_now"}, {31'd0, bus.done}, 32'd1);
      check_eq({tag, "_busy"},     {31'd0, bus.busy}, 32'd0);
      check_eq({tag, "_err_clr"},  {31'd0, bus.err},  32'd0);
    end else begin
      check_eq({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
      if (we_busy) begin
        bus.prog_we   = 1'b1;
        bus.prog_addr = we_addr[AW-1:0];
        bus.prog_data = we_data;
        for (int i = 0; i < 3; i++) step();
        bus.prog_we = 1'b0;
      end
      wait_done(tag, 200);
    end
    step();
    check_eq({tag, "_done_1cyc"}, {31'd0, bus.done}, 32'd0);
    check_eq({tag, "_pc"},    {27'd0, bus.pc},  {27'd0, exp_pc});
    check_eq({tag, "_err"},   {31'd0, bus.err}, {31'd0, exp_err});
    check_eq({tag, "_idle"},  {31'd0, bus.busy}, 32'd0);
    check_eq({tag, "_sb"},    sb_q.size(), 32'd0);
    check_eq({tag, "_ndone"}, done_cnt - d0, 32'd1);
    sb_q.delete();
  endtask

  initial begin
    logic [3:0] want;
    int d0;
    bit hit;
    n_checks = 0; n_pass = 0; done_cnt = 0;
    rst = 1'b1;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = 9'd0;
    bus.prog_len = '0;  bus.run = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b0;
    step();
    check_eq("rst_din",  {23'd0, bus.din}, 32'd0);
    check_eq("rst_pc",   {27'd0, bus.pc},  32'd0);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_done", {31'd0, bus.done}, 32'd0);
    check_eq("rst_err",  {31'd0, bus.err},  32'd0);

    // MOV_I r1, #5 ; DISP r1
    load(0, 9'h1C8); load(1, 9'h005); load(2, 9'h008);
    run_prog("movi", 3, 1'b0, 1'b0, 0, 9'd0);

    // Start from each tick phase: first word must still land on a fetch tick.
    for (int ph = 0; ph < 4; ph++) begin
      want = 4'b0001 << ph;
      for (int i = 0; i < 8; i++) begin
        if (bus.tick == want) break;
        step();
      end
      check_eq("phase_align", {28'd0, bus.tick}, {28'd0, want});
      run_prog("phase", 3, 1'b0, 1'b0, 0, 9'd0);
    end

    // MOV_I as the final word: no immediate, err set.
    load(0, 9'h048); load(1, 9'h1D0);
    run_prog("trunc", 2, 1'b0, 1'b0, 0, 9'd0);

    // Empty program: immediate done, and err from the previous run cleared.
    run_prog("empty", 0, 1'b0, 1'b0, 0, 9'd0);

    // Reset during the second instruction, then replay.
    load(0, 9'h050); load(1, 9'h088); load(2, 9'h0C1);
    push_expect(3);
    bus.prog_len = 5'd3; bus.run = 1'b1;
    step();
    bus.run = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.tick == 4'b0001 && bus.pc == 5'd1) begin
        hit = 1'b1;
        break;
      end
    end
    check_eq("rst_mid_reach", {31'd0, hit}, 32'd1);
    d0 = done_cnt;
    rst = 1'b1;
    step();
    check_eq("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_mid_din",  {23'd0, bus.din},  32'd0);
    check_eq("rst_mid_pc",   {27'd0, bus.pc},   32'd0);
    check_eq("rst_mid_done", {31'd0, bus.done}, 32'd0);
    rst = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 6; i++) step();
    check_eq("rst_mid_nodone", done_cnt - d0, 32'd0);
    run_prog("replay", 3, 1'b0, 1'b0, 0, 9'd0);

    // Writes while busy are ignored; the following run still sees 0x050 at [0].
    run_prog("wbusy", 3, 1'b0, 1'b1, 0, 9'h1FF);
    run_prog("wkept", 3, 1'b0, 1'b0, 0, 9'd0);

    // Full-depth program; last word written in the same cycle as run.
    for (int i = 0; i < DEPTH - 1; i++) load(i, 9'h040 + 9'(i));
    run_prog("full", DEPTH, 1'b1, 1'b0, DEPTH - 1, 9'h1B0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
